// File: rtl/tgc_stream_rx.sv
// tgc_stream_rx: byte-serial front end for the triangle checker.
// Optional macro TGC_TIMEOUT_EN enables the inter-byte idle timeout.
module tgc_stream_rx #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [7:0]       a_o,
    output logic [7:0]       b_o,
    output logic [7:0]       c_o,
    output logic             q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [CNT_W-1:0] pass_cnt
);

    typedef enum logic [2:0] {
        GET_A = 3'd0,
        GET_B = 3'd1,
        GET_C = 3'd2,
        EVAL  = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] op_c;

    logic       in_get;
    logic       take;
    logic       hand;
    logic       timeout_hit;
    logic       q_eval;

    logic [8:0] sum_ab;
    logic [8:0] sum_ac;
    logic [8:0] sum_bc;

    // Reject nonsensical parameterisations at elaboration.
    if (CNT_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("tgc_stream_rx: CNT_W and TIMEOUT must be >= 1");
    end

    assign in_get = (state == GET_A) || (state == GET_B) || (state == GET_C);
    assign take   = byte_valid & byte_ready;
    assign hand   = q_valid & q_ready & ~flush;

    // 9-bit sums so that large operands cannot wrap and fake a triangle.
    assign sum_ab = {1'b0, op_a} + {1'b0, op_b};
    assign sum_ac = {1'b0, op_a} + {1'b0, op_c};
    assign sum_bc = {1'b0, op_b} + {1'b0, op_c};
    assign q_eval = (sum_ab > {1'b0, op_c}) &
                    (sum_ac > {1'b0, op_b}) &
                    (sum_bc > {1'b0, op_a});

`ifdef TGC_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_run;

    assign idle_run    = (state == GET_B) || (state == GET_C);
    assign timeout_hit = idle_run && !take &&
                         (idle_cnt == IDLE_W'(TIMEOUT - 1));

    // Idle counter: counts edges without a byte while a triple is partial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (flush || take || !idle_run || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GET_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: flush and timeout both abandon the triple.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = GET_A;
        end else begin
            case (state)
                GET_A: begin
                    if (take) state_nxt = GET_B;
                end
                GET_B: begin
                    if (take)             state_nxt = GET_C;
                    else if (timeout_hit) state_nxt = GET_A;
                end
                GET_C: begin
                    if (take)             state_nxt = EVAL;
                    else if (timeout_hit) state_nxt = GET_A;
                end
                EVAL: begin
                    state_nxt = OUT;
                end
                OUT: begin
                    if (q_ready) state_nxt = GET_A;
                end
                default: begin
                    state_nxt = GET_A;
                end
            endcase
        end
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        byte_ready = rst_n & ~flush & in_get;
        q_valid    = (state == OUT);
    end

    // Operand capture, one byte per GET state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            op_c <= '0;
        end else if (take) begin
            if (state == GET_A) op_a <= byte_in;
            if (state == GET_B) op_b <= byte_in;
            if (state == GET_C) op_c <= byte_in;
        end
    end

    // Result registers load once per triple and then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_o <= '0;
            b_o <= '0;
            c_o <= '0;
            q   <= 1'b0;
        end else if ((state == EVAL) && !flush) begin
            a_o <= op_a;
            b_o <= op_b;
            c_o <= op_c;
            q   <= q_eval;
        end
    end

    // Saturating count of triangles handed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
        end else if (hand && q && (pass_cnt != '1)) begin
            pass_cnt <= pass_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tgc_stream_rx.sv
// Self-checking bench for tgc_stream_rx (directed + random triples).
// Build with +define+TGC_TIMEOUT_EN to exercise the idle timeout.
module tb_tgc_stream_rx;

    localparam int CNT_W = 8;
    localparam int TMO   = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [7:0]       byte_in = 8'd0;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic [7:0]       a_o;
    logic [7:0]       b_o;
    logic [7:0]       c_o;
    logic             q;
    logic             q_valid;
    logic             q_ready = 1'b0;
    logic [CNT_W-1:0] pass_cnt;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    tgc_stream_rx #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .a_o        (a_o),
        .b_o        (b_o),
        .c_o        (c_o),
        .q          (q),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .pass_cnt   (pass_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_tri(input int a, input int b, input int c);
        return (a + b > c) && (a + c > b) && (b + c > a);
    endfunction

    // Offer one byte and wait (bounded) for it to be taken.
    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        check("byte_accept", 32'(ok), 32'd1);
    endtask

    // Called one step after the third byte edge; checks latency,
    // the held result and the handoff.
    task automatic expect_result(input int a, input int b, input int c,
                                 input int hold);
        bit eq;
        eq = is_tri(a, b, c);
        check("eval_not_valid", 32'(q_valid), 32'd0);
        @(posedge clk);
        #1;
        check("q_valid_rise", 32'(q_valid), 32'd1);
        check("a_o", 32'(a_o), 32'(a));
        check("b_o", 32'(b_o), 32'(b));
        check("c_o", 32'(c_o), 32'(c));
        check("q", 32'(q), 32'(eq));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(q_valid), 32'd1);
            check("hold_ready", 32'(byte_ready), 32'd0);
            check("hold_a", 32'(a_o), 32'(a));
            check("hold_q", 32'(q), 32'(eq));
        end
        q_ready = 1'b1;
        @(posedge clk);
        #1;
        q_ready = 1'b0;
        if (eq && m_cnt < CMAX) m_cnt++;
        check("handoff_valid", 32'(q_valid), 32'd0);
        check("pass_cnt", 32'(pass_cnt), 32'(m_cnt));
        check("kept_c", 32'(c_o), 32'(c));
    endtask

    task automatic triple(input int a, input int b, input int c);
        send(8'(a));
        send(8'(b));
        send(8'(c));
        expect_result(a, b, c, 0);
    endtask

    initial begin
        int ra, rb, rc, mode, g;
        int v[3];

        #2;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_q_valid", 32'(q_valid), 32'd0);
        check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        check("rst_a_o", 32'(a_o), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("idle_byte_ready", 32'(byte_ready), 32'd1);

        // Degenerate, right triangle, overflow-prone sums.
        triple(3, 4, 10);
        triple(3, 4, 5);
        triple(250, 253, 214);
        triple(248, 217, 142);
        triple(195, 7, 245);
        triple(0, 5, 5);

        // Downstream stall with a byte already waiting.
        send(8'd7);
        send(8'd24);
        send(8'd25);
        byte_in    = 8'd6;
        byte_valid = 1'b1;
        expect_result(7, 24, 25, 5);
        send(8'd6);
        send(8'd8);
        send(8'd10);
        expect_result(6, 8, 10, 0);

        // Flush beats a concurrent byte and drops the partial triple.
        send(8'd21);
        send(8'd212);
        flush      = 1'b1;
        byte_in    = 8'd99;
        byte_valid = 1'b1;
        @(negedge clk);
        check("flush_ready", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        byte_valid = 1'b0;
        triple(3, 4, 5);

        // Flush beats a result handoff; no count change.
        send(8'd5);
        send(8'd5);
        send(8'd5);
        @(posedge clk);
        #1;
        check("pre_flush_valid", 32'(q_valid), 32'd1);
        flush   = 1'b1;
        q_ready = 1'b1;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        q_ready = 1'b0;
        check("flush_out_valid", 32'(q_valid), 32'd0);
        check("flush_out_cnt", 32'(pass_cnt), 32'(m_cnt));
        triple(2, 3, 4);

        // Partial triple followed by a four-cycle gap.
        send(8'd3);
        send(8'd4);
        repeat (4) @(posedge clk);
        #1;
`ifdef TGC_TIMEOUT_EN
        send(8'd3);
        send(8'd4);
        send(8'd5);
        expect_result(3, 4, 5, 0);
`else
        send(8'd3);
        expect_result(3, 4, 3, 0);
`endif

        // Random triples with short gaps and random stalls.
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 3; k++) begin
                mode = int'($urandom_range(0, 2));
                case (mode)
                    0:       v[k] = int'($urandom_range(0, 255));
                    1:       v[k] = int'($urandom_range(0, 12));
                    default: v[k] = int'($urandom_range(128, 255));
                endcase
            end
            ra = v[0];
            rb = v[1];
            rc = v[2];
            send(8'(ra));
            g = int'($urandom_range(0, 2));
            repeat (g) @(posedge clk);
            #1;
            send(8'(rb));
            g = int'($urandom_range(0, 2));
            repeat (g) @(posedge clk);
            #1;
            send(8'(rc));
            expect_result(ra, rb, rc, int'($urandom_range(0, 3)));
        end

        // Drive the pass counter into saturation.
        for (int n = 0; n < 260; n++) begin
            triple(3, 4, 5);
        end
        check("saturated", 32'(pass_cnt), 32'(CMAX));

        // Asynchronous reset mid-triple.
        send(8'd9);
        #2;
        rst_n = 1'b0;
        #1;
        m_cnt = 0;
        check("amid_ready", 32'(byte_ready), 32'd0);
        check("amid_cnt", 32'(pass_cnt), 32'd0);
        check("amid_a_o", 32'(a_o), 32'd0);
        check("amid_q", 32'(q), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        triple(4, 5, 6);

        // Asynchronous reset while a result is pending.
        send(8'd5);
        send(8'd6);
        send(8'd7);
        @(posedge clk);
        #1;
        check("pend_valid", 32'(q_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        m_cnt = 0;
        check("rmid_valid", 32'(q_valid), 32'd0);
        check("rmid_c_o", 32'(c_o), 32'd0);
        check("rmid_cnt", 32'(pass_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        triple(1, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
